// File: rtl/softmax_pkg.sv
// Shared fixed-point definitions for the softmax pipeline (pow2 and log2 stages).
// Q6.10 operands/results, plus the saturated log2 value used for a zero operand.
package softmax_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned FRAC_W = 10;
   localparam int unsigned POS_W  = 4;

   typedef logic [15:0] fxp_t;

   localparam fxp_t LOG2_ZERO = 16'h8000;

   // Integer part is (pos - 10) as a 6-bit two's-complement field above the fraction.
   function automatic fxp_t log2_pack(input logic [POS_W-1:0] pos,
                                      input logic [FRAC_W-1:0] frac);
      logic [DATA_W-FRAC_W-1:0] int_part;
      int_part = {2'b00, pos} - 6'd10;
      return {int_part, frac};
   endfunction

endpackage

// File: rtl/lod16.sv
// Combinational 16-bit leading-one detector: position of the highest set bit
// and a flag for an all-zero operand (position reads 0 in that case).
module lod16
   import softmax_pkg::*;
(
   input  logic [15:0]      x_i,
   output logic [POS_W-1:0] pos_o,
   output logic             zero_o
);

   always_comb begin
      pos_o = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (x_i[i]) pos_o = POS_W'(i);
      end
   end

   assign zero_o = ~|x_i;

endmodule

// File: rtl/stage4_log2_approx.sv
// Two-stage Mitchell log2 approximator: Q6.10 unsigned operand in, signed Q6.10
// log2 out, with a bypass copy of the operand aligned to the result.
module stage4_log2_approx #(
   parameter int unsigned DATA_W = softmax_pkg::DATA_W,
   parameter int unsigned FRAC_W = softmax_pkg::FRAC_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_x,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_log_x,
   output logic              o_zero,
   output logic [DATA_W-1:0] o_x_byp
);

   import softmax_pkg::*;

   logic [POS_W-1:0]  lod_pos;
   logic              lod_zero;

   logic [DATA_W-1:0] x_q;
   logic [POS_W-1:0]  p_q;
   logic              zero_q;
   logic              valid_q;

   logic [DATA_W-1:0] log_d, log_q;
   logic [DATA_W-1:0] byp_q;
   logic              zero2_q;
   logic              valid2_q;

   logic [POS_W-1:0]  shamt;
   logic [FRAC_W-1:0] frac;

   lod16 u_lod16 (
      .x_i    (i_x),
      .pos_o  (lod_pos),
      .zero_o (lod_zero)
   );

   // Stage 1: operand, leading-one position, zero flag, valid.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x_q     <= '0;
         p_q     <= '0;
         zero_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (i_en) begin
         x_q     <= i_x;
         p_q     <= lod_pos;
         zero_q  <= lod_zero;
         valid_q <= i_valid;
      end
   end

   // Normalize so the leading one sits at bit DATA_W-1; the next FRAC_W bits are f10.
   always_comb begin
      shamt = POS_W'(DATA_W - 1) - p_q;
      frac  = FRAC_W'((x_q << shamt) >> (DATA_W - 1 - FRAC_W));
      log_d = zero_q ? LOG2_ZERO : log2_pack(p_q, frac);
   end

   // Stage 2: result, zero flag, bypass, valid.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         log_q    <= '0;
         byp_q    <= '0;
         zero2_q  <= 1'b0;
         valid2_q <= 1'b0;
      end else if (i_en) begin
         log_q    <= log_d;
         byp_q    <= x_q;
         zero2_q  <= zero_q;
         valid2_q <= valid_q;
      end
   end

   assign o_valid = valid2_q;
   assign o_log_x = log_q;
   assign o_zero  = zero2_q;
   assign o_x_byp = byp_q;

endmodule
